// File: rtl/vscale_md_issue_if.sv
// Request/response bus between the mul/div issue stage and vscale_mul_div.
// The unit returns a single-cycle resp_valid pulse and cannot be stalled on the response side.
interface vscale_md_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic        req_out_sel;
    logic        req_in_1_signed;
    logic        req_in_2_signed;
    logic [31:0] req_in_1;
    logic [31:0] req_in_2;
    logic        resp_valid;
    logic [31:0] resp_result;

    // Request moves when req_valid & req_ready at a rising edge; req_* hold while req_valid=1.
    modport master (
        output req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
               req_in_1, req_in_2,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
               req_in_1, req_in_2,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/vscale_md_issue.sv
// Issues one decoded RV32M op to the mul/div unit, captures its response pulse and
// presents the result to writeback through a valid/ready hold buffer, with flush and watchdog.
module vscale_md_issue #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_funct,
    input  logic [4:0]               cmd_rd,
    input  logic [31:0]              cmd_rs1,
    input  logic [31:0]              cmd_rs2,
    input  logic                     flush,
    vscale_md_issue_if.master        md,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_rd,
    output logic [31:0]              wb_data,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [2:0]               state_dbg
);
    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;
    localparam logic MD_OUT_LO = 1'b0;
    localparam logic MD_OUT_HI = 1'b1;
    localparam int   CW        = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] wdog_cnt;
    logic [CW:0]   wdog_inc;
    logic          wdog_hit;
    logic          accept;
    logic          dec_op, dec_sel, dec_s1, dec_s2;

    always_comb begin
        dec_op  = MD_OP_MUL;
        dec_sel = MD_OUT_LO;
        dec_s1  = 1'b1;
        dec_s2  = 1'b1;
        unique case (cmd_funct)
            3'b000: begin dec_op = MD_OP_MUL; dec_sel = MD_OUT_LO; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b001: begin dec_op = MD_OP_MUL; dec_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b010: begin dec_op = MD_OP_MUL; dec_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b0; end
            3'b011: begin dec_op = MD_OP_MUL; dec_sel = MD_OUT_HI; dec_s1 = 1'b0; dec_s2 = 1'b0; end
            3'b100: begin dec_op = MD_OP_DIV; dec_sel = MD_OUT_LO; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b101: begin dec_op = MD_OP_DIV; dec_sel = MD_OUT_LO; dec_s1 = 1'b0; dec_s2 = 1'b0; end
            3'b110: begin dec_op = MD_OP_DIV; dec_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b111: begin dec_op = MD_OP_DIV; dec_sel = MD_OUT_HI; dec_s1 = 1'b0; dec_s2 = 1'b0; end
            default: ;
        endcase
    end

    assign cmd_ready = (state == S_IDLE) && !flush;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // The watchdog fires on the edge that would complete TIMEOUT_CYCLES cycles spent waiting.
    assign wdog_inc = {1'b0, wdog_cnt} + (CW+1)'(1);
    assign wdog_hit = (wdog_inc >= (CW+1)'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            wdog_cnt           <= '0;
            md.req_valid       <= 1'b0;
            md.req_op          <= 1'b0;
            md.req_out_sel     <= 1'b0;
            md.req_in_1_signed <= 1'b0;
            md.req_in_2_signed <= 1'b0;
            md.req_in_1        <= '0;
            md.req_in_2        <= '0;
            wb_valid           <= 1'b0;
            wb_rd              <= '0;
            wb_data            <= '0;
            timeout_err        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        md.req_op          <= dec_op;
                        md.req_out_sel     <= dec_sel;
                        md.req_in_1_signed <= dec_s1;
                        md.req_in_2_signed <= dec_s2;
                        md.req_in_1        <= cmd_rs1;
                        md.req_in_2        <= cmd_rs2;
                        wb_rd              <= cmd_rd;
                        // Writes to x0 never reach the unit; a zero result is handed back directly.
                        if (cmd_rd != 5'd0) begin
                            state        <= S_ISSUE;
                            md.req_valid <= 1'b1;
                        end else begin
                            state    <= S_HOLD;
                            wb_valid <= 1'b1;
                            wb_data  <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state        <= S_IDLE;
                        md.req_valid <= 1'b0;
                    end else if (md.req_ready) begin
                        state        <= S_WAIT;
                        md.req_valid <= 1'b0;
                        wdog_cnt     <= '0;
                    end
                end
                S_WAIT: begin
                    if (md.resp_valid) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_HOLD;
                            wb_valid <= 1'b1;
                            wb_data  <= md.resp_result;
                        end
                    end else if (wdog_hit) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        wdog_cnt    <= CW'(TIMEOUT_CYCLES);
                    end else if (flush) begin
                        state    <= S_DRAIN;
                        wdog_cnt <= '0;
                    end else begin
                        wdog_cnt <= wdog_inc[CW-1:0];
                    end
                end
                S_DRAIN: begin
                    // The unit cannot abort, so the flushed op's response is swallowed here.
                    if (md.resp_valid) begin
                        state <= S_IDLE;
                    end else if (wdog_hit) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        wdog_cnt    <= CW'(TIMEOUT_CYCLES);
                    end else begin
                        wdog_cnt <= wdog_inc[CW-1:0];
                    end
                end
                S_HOLD: begin
                    if (flush || wb_ready) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vscale_md_issue.sv
// Bench for vscale_md_issue: a behavioural mul/div unit plus an RV32M reference model
// drive directed and randomized ops through the issue stage.
module tb_vscale_md_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, flush, wb_valid, wb_ready, busy, timeout_err;
    logic [2:0]  cmd_funct, state_dbg;
    logic [4:0]  cmd_rd, wb_rd;
    logic [31:0] cmd_rs1, cmd_rs2, wb_data;

    int n_checks = 0;
    int n_errors = 0;

    vscale_md_issue_if bus();

    vscale_md_issue #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct(cmd_funct), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .flush(flush), .md(bus), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural mul/div unit ----------------
    bit          unit_en;
    int          unit_lat;
    int          ready_mode;   // 0 random, 1 always ready, 2 never ready
    logic        ready_rand = 1'b0;
    logic        spur;
    logic [31:0] spur_data;
    logic        u_busy, u_resp_valid;
    logic [31:0] u_res, u_resp_result;
    int          u_cnt, u_accepts;

    function automatic logic [31:0] unit_compute(input logic op, input logic sel, input logic s1,
                                                 input logic s2, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [31:0] q, r;
        if (op == 1'b0) begin
            ea = s1 ? {{32{a[31]}}, a} : {32'b0, a};
            eb = s2 ? {{32{b[31]}}, b} : {32'b0, b};
            p  = ea * eb;
            return sel ? p[63:32] : p[31:0];
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (s1) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return sel ? r : q;
    endfunction

    assign bus.req_ready   = !u_busy && (ready_mode == 1 || (ready_mode == 0 && ready_rand));
    assign bus.resp_valid  = u_resp_valid | spur;
    assign bus.resp_result = spur ? spur_data : u_resp_result;

    always @(negedge clk) ready_rand = 1'($urandom_range(0, 1));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_busy <= 1'b0; u_cnt <= 0; u_res <= '0;
            u_resp_valid <= 1'b0; u_resp_result <= '0; u_accepts <= 0;
        end else begin
            u_resp_valid <= 1'b0;
            if (u_busy) begin
                if (u_cnt == 0) begin
                    u_resp_valid  <= 1'b1;
                    u_resp_result <= u_res;
                    u_busy        <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end else if (bus.req_valid && bus.req_ready) begin
                u_accepts <= u_accepts + 1;
                if (unit_en) begin
                    u_busy <= 1'b1;
                    u_cnt  <= unit_lat;
                    u_res  <= unit_compute(bus.req_op, bus.req_out_sel, bus.req_in_1_signed,
                                           bus.req_in_2_signed, bus.req_in_1, bus.req_in_2);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin p = (b == 0) ? -1 : sa / sb; return p[31:0]; end
            3'b101: begin p = (b == 0) ? -1 : ua / ub; return p[31:0]; end
            3'b110: begin p = (b == 0) ? ua : sa % sb; return p[31:0]; end
            default: begin p = (b == 0) ? ua : ua % ub; return p[31:0]; end
        endcase
    endfunction

    // {op, out_sel, in_1_signed, in_2_signed}; MUL/LO = 0, DIV/HI = 1
    function automatic logic [3:0] exp_dec(input logic [2:0] f);
        case (f)
            3'b000: return 4'b0011;
            3'b001: return 4'b0111;
            3'b010: return 4'b0110;
            3'b011: return 4'b0100;
            3'b100: return 4'b1011;
            3'b101: return 4'b1000;
            3'b110: return 4'b1111;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept_cmd(input string tag, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
        int w;
        w = 0;
        while (!cmd_ready && w < 100) begin tick(); w++; end
        check({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_funct = f; cmd_rs1 = a; cmd_rs2 = b; cmd_rd = rd;
        tick();
        cmd_valid = 1'b0; cmd_rs1 = $urandom(); cmd_rs2 = $urandom();
        cmd_funct = 3'($urandom_range(0, 7)); cmd_rd = 5'($urandom_range(0, 31));
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold, input bit flush_rel);
        logic [31:0] exp_q[$];
        logic [3:0]  dec;
        int          waited, acc0;
        bit          req_ok, hold_ok, prev_resp;
        exp_q.push_back((rd == 0) ? 32'd0 : rv32m(f, a, b));
        dec  = exp_dec(f);
        acc0 = u_accepts;
        accept_cmd(tag, f, a, b, rd);
        check({tag, " busy"}, busy, 1);
        check({tag, " req_valid at N+1"}, bus.req_valid, (rd != 0) ? 1 : 0);
        if (rd != 0) begin
            check({tag, " req decode"},
                  {bus.req_op, bus.req_out_sel, bus.req_in_1_signed, bus.req_in_2_signed}, dec);
            check({tag, " req_in_1"}, bus.req_in_1, a);
            check({tag, " req_in_2"}, bus.req_in_2, b);
        end
        req_ok = 1; prev_resp = 0; waited = 0;
        while (!wb_valid && waited < 300) begin
            if (bus.req_valid && ({bus.req_op, bus.req_out_sel, bus.req_in_1_signed,
                bus.req_in_2_signed} !== dec || bus.req_in_1 !== a || bus.req_in_2 !== b)) req_ok = 0;
            prev_resp = bus.resp_valid;
            tick();
            waited++;
        end
        check({tag, " wb_valid seen"}, wb_valid, 1);
        check({tag, " req stable"}, req_ok, 1);
        if (rd == 0) check({tag, " rd0 immediate wb"}, waited, 0);
        else         check({tag, " wb after resp"}, prev_resp, 1);
        check({tag, " wb_rd"}, wb_rd, rd);
        check({tag, " wb_data"}, wb_data, exp_q[0]);
        hold_ok = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (wb_valid !== 1'b1 || wb_data !== exp_q[0] || wb_rd !== rd || bus.req_valid !== 1'b0) hold_ok = 0;
        end
        check({tag, " hold stable"}, hold_ok, 1);
        wb_ready = 1'b1;
        flush = flush_rel;
        tick();
        wb_ready = 1'b0;
        flush = 1'b0;
        check({tag, " wb released"}, wb_valid, 0);
        check({tag, " idle after"}, busy, 0);
        check({tag, " unit requests"}, u_accepts - acc0, (rd != 0) ? 1 : 0);
        void'(exp_q.pop_front());
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, nwait;
        bit cr_ok, wb_ok, early;
        reset = 1'b0; cmd_valid = 1'b0; cmd_funct = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        flush = 1'b0; wb_ready = 1'b0; spur = 1'b0; spur_data = '0;
        unit_en = 1; unit_lat = 2; ready_mode = 1;
        #3;
        check("rst req_valid", bus.req_valid, 0);
        check("rst req fields", {bus.req_op, bus.req_out_sel, bus.req_in_1_signed, bus.req_in_2_signed}, 0);
        check("rst req_in_1", bus.req_in_1, 0);
        check("rst req_in_2", bus.req_in_2, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_rd", wb_rd, 0);
        check("rst wb_data", wb_data, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst busy", busy, 0);
        check("rst state", state_dbg, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("idle cmd_ready", cmd_ready, 1);

        do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 2, 0);
        do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1, 0);
        unit_lat = 4;
        do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 10, 0);
        do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 10, 0);
        do_op("rd0", 3'b000, 32'd123, 32'd456, 5'd0, 2, 0);
        unit_lat = 0;
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0);
        do_op("divu0", 3'b101, 32'd55, 32'd0, 5'd8, 0, 0);
        do_op("remu0", 3'b111, 32'd55, 32'd0, 5'd8, 0, 0);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'h8000_0000, 5'd31, 1, 0);
        do_op("hold_flush", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 2, 1);

        // Stray response and wb_ready while idle
        spur = 1'b1; spur_data = 32'hDEAD_BEEF; wb_ready = 1'b1;
        tick();
        spur = 1'b0; wb_ready = 1'b0;
        tick();
        check("spur wb_valid", wb_valid, 0);
        check("spur busy", busy, 0);

        // Flush while the request is still being offered
        ready_mode = 2;
        n = u_accepts;
        accept_cmd("flush_issue", 3'b100, 32'd100, 32'd3, 5'd4);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_issue req_valid", bus.req_valid, 0);
        check("flush_issue busy", busy, 0);
        check("flush_issue no req", u_accepts - n, 0);
        ready_mode = 1;

        // Flush two cycles into WAIT: response is drained, nothing reaches writeback
        unit_lat = 6;
        accept_cmd("flush_wait", 3'b100, 32'd1000, 32'd7, 5'd12);
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait drain state", state_dbg, 3);
        cr_ok = 1; wb_ok = 1; nwait = 0;
        while (!bus.resp_valid && nwait < 50) begin
            if (cmd_ready !== 1'b0) cr_ok = 0;
            if (wb_valid !== 1'b0) wb_ok = 0;
            tick();
            nwait++;
        end
        check("flush_wait resp seen", bus.resp_valid, 1);
        check("flush_wait cmd_ready low", cr_ok & (cmd_ready === 1'b0), 1);
        tick();
        check("flush_wait cmd_ready after", cmd_ready, 1);
        check("flush_wait no wb", wb_ok & (wb_valid === 1'b0), 1);

        // Flush coincident with the response pulse drops the result
        unit_lat = 0;
        accept_cmd("flush_resp", 3'b000, 32'd3, 32'd5, 5'd2);
        tick();
        tick();
        check("flush_resp pulse", bus.resp_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_resp busy", busy, 0);
        check("flush_resp wb_valid", wb_valid, 0);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rd;
            ready_mode = 0;
            unit_lat = $urandom_range(0, 6);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), rd,
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
        ready_mode = 1;

        // Asynchronous reset in the middle of an op
        unit_lat = 10;
        accept_cmd("mid_reset", 3'b101, 32'd77, 32'd5, 5'd9);
        tick();
        #2 reset = 1'b0;
        #1;
        check("mid_reset busy", busy, 0);
        check("mid_reset req_valid", bus.req_valid, 0);
        check("mid_reset req_in_1", bus.req_in_1, 0);
        check("mid_reset wb_rd", wb_rd, 0);
        tick();
        reset = 1'b1;
        tick();

        // Watchdog: the unit never answers
        unit_en = 0;
        accept_cmd("timeout", 3'b000, 32'd2, 32'd3, 5'd4);
        n = 0; early = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (n == 64) early = timeout_err;
        end
        check("timeout cycles", n, 65);
        check("timeout not early", early, 0);
        check("timeout_err set", timeout_err, 1);
        check("timeout state", state_dbg, 0);
        check("timeout wb_valid", wb_valid, 0);
        unit_en = 1;
        unit_lat = 1;
        do_op("after_timeout", 3'b001, 32'hFFFF_FFFF, 32'd2, 5'd10, 0, 0);
        check("timeout_err sticky", timeout_err, 1);
        #2 reset = 1'b0;
        #1;
        check("timeout_err cleared", timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
